// File: rtl/uio_bank_pkg.sv
// Shared types for the bidirectional pin bank controller: pin modes, control
// FSM states and bit positions of the command write/read data words.
package uio_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_DRIVE = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_INPUT = 2'b11
    } pin_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } ctrl_state_e;

    // write data fields
    localparam int WD_MODE_LSB  = 0;
    localparam int WD_LEVEL_BIT = 2;

    // read data fields
    localparam int RD_MODE_LSB  = 0;
    localparam int RD_LEVEL_BIT = 2;
    localparam int RD_PAD_BIT   = 3;
    localparam int RD_CNT_LSB   = 4;

    function automatic logic [7:0] pack_rdata(input pin_mode_e  mode,
                                              input logic       level,
                                              input logic       pad,
                                              input logic [3:0] cnt);
        logic [7:0] r;
        r                     = 8'h00;
        r[RD_MODE_LSB +: 2]   = mode;
        r[RD_LEVEL_BIT]       = level;
        r[RD_PAD_BIT]         = pad;
        r[RD_CNT_LSB +: 4]    = cnt;
        return r;
    endfunction

endpackage

// File: rtl/uio_bank_ctrl_if.sv
// Command/response bus of the pin bank controller. The requester (master)
// issues one command at a time; the bank (slave) answers with a one-cycle
// response strobe.
interface uio_bank_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/uio_pin_cell.sv
// One managed pin: mode/level registers, 2-flop input synchronizer, registered
// output mux and, when UIO_EDGE_CNT_EN is defined, a saturating 4-bit
// rising-edge counter on the synchronized input (counts only in INPUT mode).
module uio_pin_cell
    import uio_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic       wr_en_i,
    input  logic       rd_en_i,
    input  logic [2:0] wdata_i,
    input  logic       blink_i,
    input  logic       pad_in_i,
    output logic       pad_out_o,
    output logic       pad_oe_o,
    output logic [7:0] rdata_o
);

    pin_mode_e  mode_q, mode_d;
    logic       level_q, level_d;
    logic       sync1_q, sync2_q;
    logic       out_q, out_d;
    logic       oe_q, oe_d;
    logic [3:0] cnt_w;

    // a write command replaces mode and level
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        if (wr_en_i) begin
            mode_d  = pin_mode_e'(wdata_i[WD_MODE_LSB +: 2]);
            level_d = wdata_i[WD_LEVEL_BIT];
        end
    end

    // mode and level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            level_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
        end
    end

    // two-flop synchronizer on the pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
        end
    end

    // output mux selected by the current mode
    always_comb begin
        out_d = 1'b0;
        oe_d  = 1'b0;
        unique case (mode_q)
            MODE_DRIVE: begin
                oe_d  = 1'b1;
                out_d = level_q;
            end
            MODE_BLINK: begin
                oe_d  = 1'b1;
                out_d = blink_i;
            end
            default: begin
                oe_d  = 1'b0;
                out_d = 1'b0;
            end
        endcase
    end

    // registered pad drivers, one edge behind the mode/level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
            oe_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            oe_q  <= oe_d;
        end
    end

`ifdef UIO_EDGE_CNT_EN
    logic       prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic       rise;

    assign rise = sync2_q & ~prev_q & ena_i & (mode_q == MODE_INPUT);

    // write clears; read clears but keeps an edge landing on the same cycle
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en_i) begin
            cnt_d = 4'd0;
        end else if (rd_en_i) begin
            cnt_d = {3'b000, rise};
        end else if (rise && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // edge detector history and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            prev_q <= sync2_q;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_w = cnt_q;
`else
    assign cnt_w = 4'd0;
`endif

    assign pad_out_o = out_q;
    assign pad_oe_o  = oe_q;
    assign rdata_o   = pack_rdata(mode_q, level_q, sync2_q, cnt_w);

endmodule

// File: rtl/uio_bank_ctrl.sv
// Bank of WIDTH bidirectional pins behind a single-outstanding command bus.
// A command accepted at edge N executes at N+1 and is answered with a
// one-cycle rsp_valid after N+2. A shared prescaler supplies the blink phase.
// Optional feature macro: UIO_EDGE_CNT_EN (per-pin rising-edge counters).
module uio_bank_ctrl
    import uio_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    uio_bank_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe
);

    ctrl_state_e      state_q, state_d;
    logic             accept;
    logic             wr_q;
    logic [2:0]       addr_q;
    logic [2:0]       wdata_q;
    logic [7:0]       cap_q;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             blink_q, blink_d;
    logic             exec_wr, exec_rd;
    logic [7:0]       cell_rdata [8];

    // ready is forced low while reset is held, independent of the state register
    assign bus.cmd_ready = rst_n && ena && (state_q == ST_IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // control state and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // next state and response strobe
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = cap_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // latch the accepted command, capture read data during EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 3'd0;
            cap_q   <= 8'h00;
        end else begin
            if (accept) begin
                wr_q    <= bus.cmd_wr;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata[2:0];
            end
            if (state_q == ST_EXEC) begin
                cap_q <= wr_q ? 8'h00 : cell_rdata[addr_q];
            end
        end
    end

    assign exec_wr = (state_q == ST_EXEC) &&  wr_q;
    assign exec_rd = (state_q == ST_EXEC) && !wr_q;

    // prescaler advance and blink toggle on wrap, frozen while disabled
    always_comb begin
        presc_d = presc_q;
        blink_d = blink_q;
        if (ena) begin
            presc_d = presc_q + 1'b1;
            if (&presc_q) blink_d = ~blink_q;
        end
    end

    // prescaler and blink phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            blink_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
        end
    end

    // addresses with no pin behind them read as zero and ignore writes
    for (genvar i = 0; i < 8; i++) begin : g_pin
        if (i < WIDTH) begin : g_cell
            uio_pin_cell u_cell (
                .clk       (clk),
                .rst_n     (rst_n),
                .ena_i     (ena),
                .wr_en_i   (exec_wr && (addr_q == 3'(i))),
                .rd_en_i   (exec_rd && (addr_q == 3'(i))),
                .wdata_i   (wdata_q),
                .blink_i   (blink_q),
                .pad_in_i  (pad_in[i]),
                .pad_out_o (pad_out[i]),
                .pad_oe_o  (pad_oe[i]),
                .rdata_o   (cell_rdata[i])
            );
        end else begin : g_empty
            assign cell_rdata[i] = 8'h00;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_uio_bank_ctrl.sv
// Scoreboard bench for uio_bank_ctrl (WIDTH=4, DIV_W=4): a transaction-level
// reference model predicts pad outputs, ready and responses; a monitor
// compares them every cycle. Directed sequences cover the key scenarios,
// followed by randomized traffic and a reset during command execution.
module tb_uio_bank_ctrl;
    import uio_bank_pkg::*;

    localparam int W  = 4;
    localparam int DW = 4;
`ifdef UIO_EDGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         ena    = 1'b0;
    logic [W-1:0] pad_in = '0;
    logic [W-1:0] pad_out, pad_oe;

    uio_bank_ctrl_if bus ();

    uio_bank_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .bus     (bus),
        .pad_in  (pad_in),
        .pad_out (pad_out),
        .pad_oe  (pad_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    rsp_t         rsp_q[$];
    int           cyc = 0;
    logic [1:0]   m_mode [W];
    logic         m_level [W];
    int           m_cnt [W];
    logic [W-1:0] h1 = '0, h2 = '0, h3 = '0;
    int           ena_cnt = 0;
    int           last_acc = -10;
    logic         c_wr;
    logic [2:0]   c_addr;
    logic [7:0]   c_wdata;
    logic [W-1:0] exp_oe = '0, exp_out = '0;
    logic         exp_idle = 1'b1;

    always @(posedge clk) begin
        logic         blink;
        logic [W-1:0] rise;
        logic [7:0]   rd;
        bit           acc, exec, inc;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                m_mode[i] = 2'b00; m_level[i] = 1'b0; m_cnt[i] = 0;
            end
            h1 = '0; h2 = '0; h3 = '0;
            ena_cnt = 0; last_acc = -10;
            exp_oe = '0; exp_out = '0; exp_idle = 1'b1;
            rsp_q.delete();
        end else begin
            blink = ((ena_cnt >> DW) & 1) != 0;
            for (int i = 0; i < W; i++) begin
                exp_oe[i]  = (m_mode[i] == 2'b01) || (m_mode[i] == 2'b10);
                exp_out[i] = (m_mode[i] == 2'b01) ? m_level[i] :
                             (m_mode[i] == 2'b10) ? blink : 1'b0;
            end
            rise = h2 & ~h3;
            acc  = bus.cmd_valid && ena && (cyc >= last_acc + 3);
            exec = (cyc == last_acc + 1);
            if (exec) begin
                rd = 8'h00;
                if (!c_wr) begin
                    for (int i = 0; i < W; i++)
                        if (c_addr == 3'(i))
                            rd = {(CNT_EN ? 4'(m_cnt[i]) : 4'h0), h2[i], m_level[i], m_mode[i]};
                end
                rsp_q.push_back('{due: cyc + 1, data: rd});
            end
            for (int i = 0; i < W; i++) begin
                inc = ena && rise[i] && (m_mode[i] == 2'b11);
                if (exec && (c_addr == 3'(i)) && c_wr) begin
                    m_mode[i]  = c_wdata[1:0];
                    m_level[i] = c_wdata[2];
                    m_cnt[i]   = 0;
                end else if (exec && (c_addr == 3'(i))) begin
                    m_cnt[i] = inc ? 1 : 0;
                end else if (inc && m_cnt[i] < 15) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (acc) begin
                last_acc = cyc;
                c_wr = bus.cmd_wr; c_addr = bus.cmd_addr; c_wdata = bus.cmd_wdata;
            end
            if (ena) ena_cnt++;
            h3 = h2; h2 = h1; h1 = pad_in;
            exp_idle = (cyc >= last_acc + 2);
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        bit   exp_valid;
        rsp_t r;
        #1;
        chk("cmd_ready", bus.cmd_ready, rst_n && ena && exp_idle);
        chk("pad_oe", pad_oe, exp_oe);
        chk("pad_out", pad_out, exp_out);
        if (!rst_n) chk("rsp_rdata_in_reset", bus.rsp_rdata, 8'h00);
        exp_valid = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
        chk("rsp_valid", bus.rsp_valid, exp_valid);
        if (exp_valid) begin
            r = rsp_q.pop_front();
            if (bus.rsp_valid) chk("rsp_rdata", bus.rsp_rdata, r.data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cmd(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output int lat);
        int guard;
        rdata = 8'h00;
        lat   = -1;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                rdata = bus.rsp_rdata;
                lat   = k;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         lat;
        int         tog[$];
        logic       prev;

        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_wdata = 8'h00;
        ena = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", bus.cmd_ready, 1'b1);
        chk("oe_after_release", pad_oe, 4'h0);
        chk("out_after_release", pad_out, 4'h0);

        // drive mode with level high, then read back with pad high
        pad_in[2] = 1'b1;
        do_cmd(1'b1, 3'd2, 8'h05, rd, lat);
        chk("write_latency", lat, 3);
        chk("write_rdata", rd, 8'h00);
        @(negedge clk);
        chk("rsp_single_pulse", bus.rsp_valid, 1'b0);
        chk("drive_oe2", pad_oe[2], 1'b1);
        chk("drive_out2", pad_out[2], 1'b1);
        do_cmd(1'b0, 3'd2, 8'h00, rd, lat);
        chk("read_pin2", rd, 8'h0D);

        // blink period with a 4-bit prescaler
        do_cmd(1'b1, 3'd0, 8'h02, rd, lat);
        prev = pad_out[0];
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (pad_out[0] !== prev) begin
                tog.push_back(k);
                prev = pad_out[0];
            end
        end
        chk("blink_toggle_count_ge4", tog.size() >= 4, 1'b1);
        for (int k = 1; k < tog.size(); k++) chk("blink_period", tog[k] - tog[k-1], 16);

        // edge counter saturation and read-clear
        do_cmd(1'b1, 3'd1, 8'h03, rd, lat);
        repeat (20) begin
            pad_in[1] = 1'b1;
            repeat (2) @(negedge clk);
            pad_in[1] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        do_cmd(1'b0, 3'd1, 8'h00, rd, lat);
        chk("edge_count_saturated", rd, CNT_EN ? 8'hF3 : 8'h03);
        do_cmd(1'b0, 3'd1, 8'h00, rd, lat);
        chk("edge_count_cleared", rd, 8'h03);

        // address beyond the bank
        do_cmd(1'b0, 3'd7, 8'h00, rd, lat);
        chk("oob_read_rdata", rd, 8'h00);
        chk("oob_read_latency", lat, 3);
        @(negedge clk);
        chk("oob_single_pulse", bus.rsp_valid, 1'b0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            ena           = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) pad_in = pad_in ^ W'($urandom);
            bus.cmd_valid = $urandom_range(0, 1) == 1;
            bus.cmd_wr    = $urandom_range(0, 1) == 1;
            bus.cmd_addr  = 3'($urandom_range(0, 7));
            bus.cmd_wdata = 8'($urandom);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ena = 1'b1;
        repeat (5) @(negedge clk);

        // make sure some pin drives so the reset visibly clears it
        do_cmd(1'b1, 3'd2, 8'h01, rd, lat);

        // reset while a command is executing
        begin
            int guard;
            guard = 0;
            while (!bus.cmd_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 3'd3; bus.cmd_wdata = 8'h01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_in_reset", bus.rsp_valid, 1'b0);
        end
        chk("oe_in_reset", pad_oe, 4'h0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_rsp_after_reset", bus.rsp_valid, 1'b0);
        end
        for (int a = 0; a < W; a++) begin
            do_cmd(1'b0, 3'(a), 8'h00, rd, lat);
            chk("pin_off_after_reset", rd & 8'h07, 8'h00);
            chk("read_latency_after_reset", lat, 3);
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
